sequential_divider: RTL and testbench

Multi-cycle unsigned restoring divider producing quotient and remainder of two `DIV_WIDTH`-bit operands, one quotient bit per clock. It is the inverse-operation companion to the team's combinational array multiplier, used where area matters more than latency and a start/done handshake is acceptable. A bench can close the loop by multiplying the results back: `quotient*divisor + remainder == dividend`.

---
 rtl/sequential_divider.sv | 151 +++++++++++++++
 tb/tb_sequential_divider.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// sequential_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk_in        rising-edge clock
//   rst_in        synchronous, active-high reset
//   start_in      request a division (sampled only in IDLE)
//   dividend_in   unsigned dividend, captured on the accepting edge
//   divisor_in    unsigned divisor, captured on the accepting edge
//   busy_out      high while the iteration is running
//   done_out      single-cycle pulse, results valid
//   quotient_out  registered quotient
//   remainder_out registered remainder
//   div_zero_out  divisor was zero for the last completed operation
//
// Optional feature: define SEQ_DIV_ZERO_EARLY_EN to let a zero divisor skip the
// iteration and go straight to DONE with quotient all ones and remainder = dividend.
// Without it a zero divisor runs the full iteration, which yields the same result.

module sequential_divider #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [DIV_WIDTH-1:0] dividend_in,
  input  logic [DIV_WIDTH-1:0] divisor_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [DIV_WIDTH-1:0] quotient_out,
  output logic [DIV_WIDTH-1:0] remainder_out,
  output logic                 div_zero_out
);

  localparam int unsigned CntW = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]      cnt_q;
  logic [DIV_WIDTH:0]   rem_q;       // partial remainder, one bit wider than operands
  logic [DIV_WIDTH-1:0] quo_q;       // shifted dividend, becomes the quotient
  logic [DIV_WIDTH-1:0] dvs_q;
  logic                 zero_q;      // captured divisor was zero
  logic [DIV_WIDTH-1:0] quotient_q;
  logic [DIV_WIDTH-1:0] remainder_q;
  logic                 div_zero_q;

  logic [DIV_WIDTH:0]   r_shift;
  logic [DIV_WIDTH:0]   trial;
  logic                 step_ok;
  logic [DIV_WIDTH:0]   rem_step;
  logic [DIV_WIDTH-1:0] quo_step;

  // Restoring step: shift {R,Q} left, try subtracting the divisor, keep it if non-negative.
  always_comb begin
    r_shift  = {rem_q[DIV_WIDTH-1:0], quo_q[DIV_WIDTH-1]};
    trial    = r_shift - {1'b0, dvs_q};
    step_ok  = ~trial[DIV_WIDTH];
    rem_step = step_ok ? trial : r_shift;
    quo_step = {quo_q[DIV_WIDTH-2:0], step_ok};
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
`ifdef SEQ_DIV_ZERO_EARLY_EN
          state_d = (divisor_in == '0) ? StDone : StCalc;
`else
          state_d = StCalc;
`endif
        end
      end
      StCalc: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode the state register only; no input reaches an output combinationally.
  always_comb begin
    busy_out = (state_q == StCalc);
    done_out = (state_q == StDone);
  end

  // Datapath and result registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            rem_q  <= '0;
            quo_q  <= dividend_in;
            dvs_q  <= divisor_in;
            zero_q <= (divisor_in == '0);
            cnt_q  <= CntW'(DIV_WIDTH - 1);
`ifdef SEQ_DIV_ZERO_EARLY_EN
            if (divisor_in == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend_in;
              div_zero_q  <= 1'b1;
            end
`endif
          end
        end
        StCalc: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          if (cnt_q == '0) begin
            quotient_q  <= quo_step;
            remainder_q <= rem_step[DIV_WIDTH-1:0];
            div_zero_q  <= zero_q;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient_out  = quotient_q;
  assign remainder_out = remainder_q;
  assign div_zero_out  = div_zero_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and loop-back bench for sequential_divider at DIV_WIDTH = 8.
module tb_sequential_divider;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       start_in;
  logic [7:0] dividend_in;
  logic [7:0] divisor_in;
  logic       busy_out;
  logic       done_out;
  logic [7:0] quotient_out;
  logic [7:0] remainder_out;
  logic       div_zero_out;

  int checks   = 0;
  int failures = 0;

  sequential_divider #(.DIV_WIDTH(8)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .dividend_in   (dividend_in),
    .divisor_in    (divisor_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out),
    .div_zero_out  (div_zero_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Called just after the accepting edge; scrambles operands every cycle and returns in
  // the DONE cycle (or after the budget expires).
  task automatic wait_done(output logic [7:0] q, output logic [7:0] r, output logic dz,
                           output int lat, output int bcnt);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    bcnt = 0;
    q    = '0;
    r    = '0;
    dz   = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      check_val("busy_done_excl", 32'(busy_out & done_out), 0);
      if (busy_out) bcnt++;
      if (done_out) begin
        seen = 1'b1;
        lat  = k + 1;
        q    = quotient_out;
        r    = remainder_out;
        dz   = div_zero_out;
      end else begin
        dividend_in = 8'($urandom_range(0, 255));
        divisor_in  = 8'($urandom_range(1, 255));
        tick();
      end
    end
    check_val("done_seen", 32'(seen), 1);
  endtask

  task automatic run_div(input logic [7:0] a, input logic [7:0] b, output logic [7:0] q,
                         output logic [7:0] r, output logic dz, output int lat,
                         output int bcnt);
    start_in    = 1'b1;
    dividend_in = a;
    divisor_in  = b;
    tick();
    start_in = 1'b0;
    wait_done(q, r, dz, lat, bcnt);
    tick();  // DONE -> IDLE
  endtask

  logic [7:0] q, r;
  logic       dz;
  int         lat, bcnt, dcnt;
  int         a_i, b_i;

  initial begin
    rst_in      = 1'b1;
    start_in    = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    tick();
    tick();
    rst_in = 1'b0;
    check_val("rst_busy", 32'(busy_out), 0);
    check_val("rst_done", 32'(done_out), 0);
    check_val("rst_quo", 32'(quotient_out), 0);
    check_val("rst_rem", 32'(remainder_out), 0);
    check_val("rst_dz", 32'(div_zero_out), 0);

    // 200 / 7
    run_div(8'd200, 8'd7, q, r, dz, lat, bcnt);
    check_val("d200_7_quo", 32'(q), 28);
    check_val("d200_7_rem", 32'(r), 4);
    check_val("d200_7_lat", 32'(lat), 9);
    check_val("d200_7_busy", 32'(bcnt), 8);
    check_val("d200_7_dz", 32'(dz), 0);

    run_div(8'd250, 8'd5, q, r, dz, lat, bcnt);
    check_val("d250_5_quo", 32'(q), 50);
    check_val("d250_5_rem", 32'(r), 0);
    run_div(8'd255, 8'd1, q, r, dz, lat, bcnt);
    check_val("d255_1_quo", 32'(q), 255);
    check_val("d255_1_rem", 32'(r), 0);
    run_div(8'd13, 8'd200, q, r, dz, lat, bcnt);
    check_val("d13_200_quo", 32'(q), 0);
    check_val("d13_200_rem", 32'(r), 13);

    // Divide by zero
    run_div(8'd77, 8'd0, q, r, dz, lat, bcnt);
    check_val("d77_0_quo", 32'(q), 255);
    check_val("d77_0_rem", 32'(r), 77);
    check_val("d77_0_dz", 32'(dz), 1);
`ifdef SEQ_DIV_ZERO_EARLY_EN
    check_val("d77_0_lat", 32'(lat), 1);
    check_val("d77_0_busy", 32'(bcnt), 0);
`else
    check_val("d77_0_lat", 32'(lat), 9);
    check_val("d77_0_busy", 32'(bcnt), 8);
`endif
    run_div(8'd9, 8'd3, q, r, dz, lat, bcnt);
    check_val("d9_3_quo", 32'(q), 3);
    check_val("d9_3_rem", 32'(r), 0);
    check_val("d9_3_dz", 32'(dz), 0);

    // start_in held high throughout 100 / 9
    start_in    = 1'b1;
    dividend_in = 8'd100;
    divisor_in  = 8'd9;
    tick();                       // edge 0
    wait_done(q, r, dz, lat, bcnt);  // returns after edge 8
    check_val("held_quo", 32'(q), 11);
    check_val("held_rem", 32'(r), 1);
    check_val("held_lat", 32'(lat), 9);
    dividend_in = 8'd50;
    divisor_in  = 8'd5;
    tick();                       // edge 9: DONE -> IDLE, start ignored
    check_val("held_e9_busy", 32'(busy_out), 0);
    check_val("held_e9_done", 32'(done_out), 0);
    tick();                       // edge 10: accepted
    check_val("held_e10_busy", 32'(busy_out), 1);
    start_in = 1'b0;
    wait_done(q, r, dz, lat, bcnt);
    check_val("held2_quo", 32'(q), 10);
    check_val("held2_rem", 32'(r), 0);
    check_val("held2_lat", 32'(lat), 9);
    tick();

    // Reset at CALC step 4 of 180 / 11
    start_in    = 1'b1;
    dividend_in = 8'd180;
    divisor_in  = 8'd11;
    tick();                       // edge 0
    start_in = 1'b0;
    tick();
    tick();
    tick();                       // edges 1..3
    rst_in = 1'b1;
    tick();                       // edge 4
    rst_in = 1'b0;
    check_val("mrst_busy", 32'(busy_out), 0);
    check_val("mrst_done", 32'(done_out), 0);
    check_val("mrst_quo", 32'(quotient_out), 0);
    check_val("mrst_rem", 32'(remainder_out), 0);
    check_val("mrst_dz", 32'(div_zero_out), 0);
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (done_out) dcnt++;
      tick();
    end
    check_val("mrst_no_done", 32'(dcnt), 0);
    run_div(8'd180, 8'd11, q, r, dz, lat, bcnt);
    check_val("d180_11_quo", 32'(q), 16);
    check_val("d180_11_rem", 32'(r), 4);

    // Loop-back over random pairs with forced corner values
    for (int i = 0; i < 200; i++) begin
      a_i = int'($urandom_range(0, 255));
      b_i = int'($urandom_range(0, 255));
      case (i % 10)
        0: b_i = 0;
        1: a_i = 255;
        2: b_i = 255;
        3: a_i = 0;
        4: begin a_i = 255; b_i = 0; end
        default: ;
      endcase
      run_div(8'(a_i), 8'(b_i), q, r, dz, lat, bcnt);
      check_val($sformatf("loop_%0d_%0d", a_i, b_i), 32'(int'(q) * b_i + int'(r)), 32'(a_i));
      check_val($sformatf("loop_dz_%0d", b_i), 32'(dz), 32'(b_i == 0));
      if (b_i != 0) begin
        check_val($sformatf("loop_rlt_%0d_%0d", a_i, b_i), 32'(int'(r) < b_i), 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
